// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding, owner ids
// and the fill bit used for read data of an aborted access.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  // A timed-out read returns every data bit set to this value.
  localparam logic ERR_FILL_BIT = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the CPU and bit 1 is the debug port;
// on a tie the requester that did not win last time is granted.
module mem_bus_arbiter_rr_arb2
  import mem_bus_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_grant
);

  logic r_rrLast;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = (r_rrLast == OWNER_DBG) ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rrLast <= OWNER_DBG;
    end else if (|o_grant) begin
      r_rrLast <= o_grant[1];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between the CPU and the debug/loader port,
// running a req/ack handshake with memory under a timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpuReq,
  input  logic                  cpuWe,
  input  logic [ADDR_WIDTH-1:0] cpuAddr,
  input  logic [DATA_WIDTH-1:0] cpuWdata,
  output logic [DATA_WIDTH-1:0] cpuRdata,
  output logic                  cpuAck,
  output logic                  cpuStall,
  input  logic                  dbgReq,
  input  logic                  dbgWe,
  input  logic [ADDR_WIDTH-1:0] dbgAddr,
  input  logic [DATA_WIDTH-1:0] dbgWdata,
  output logic [DATA_WIDTH-1:0] dbgRdata,
  output logic                  dbgAck,
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWdata,
  input  logic [DATA_WIDTH-1:0] memRdata,
  input  logic                  memAck,
  output logic                  errPulse,
  output logic                  errOwner
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            w_grant;
  logic                  w_expire;
  logic                  r_owner;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [7:0]            r_cnt;
  logic                  r_err;
  logic                  r_errOwner;
  logic [DATA_WIDTH-1:0] r_cpuRdata;
  logic [DATA_WIDTH-1:0] r_dbgRdata;

  mem_bus_arbiter_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req   ({dbgReq, cpuReq}),
    .i_en    (r_state == ST_IDLE),
    .o_grant (w_grant)
  );

  // Expiry is judged on the incremented count so the Nth WAIT cycle aborts.
  assign w_expire = ((r_cnt + 8'd1) == LP_TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    memReq      = 1'b0;
    cpuAck      = 1'b0;
    dbgAck      = 1'b0;
    errPulse    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_grant) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        memReq = 1'b1;
        if (memAck || w_expire) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        cpuAck      = (r_owner == OWNER_CPU);
        dbgAck      = (r_owner == OWNER_DBG);
        errPulse    = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner    <= OWNER_CPU;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= 8'd0;
      r_err      <= 1'b0;
      r_errOwner <= OWNER_CPU;
      r_cpuRdata <= '0;
      r_dbgRdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_owner <= w_grant[1];
            r_we    <= w_grant[1] ? dbgWe    : cpuWe;
            r_addr  <= w_grant[1] ? dbgAddr  : cpuAddr;
            r_wdata <= w_grant[1] ? dbgWdata : cpuWdata;
            r_cnt   <= 8'd0;
          end
        end
        ST_WAIT: begin
          // A memAck in the expiry cycle still wins over the timeout.
          if (memAck) begin
            r_err <= 1'b0;
            if (r_owner == OWNER_DBG) r_dbgRdata <= memRdata;
            else                      r_cpuRdata <= memRdata;
          end else if (w_expire) begin
            r_err      <= 1'b1;
            r_errOwner <= r_owner;
            if (r_owner == OWNER_DBG) r_dbgRdata <= {DATA_WIDTH{ERR_FILL_BIT}};
            else                      r_cpuRdata <= {DATA_WIDTH{ERR_FILL_BIT}};
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign memWe    = r_we;
  assign memAddr  = r_addr;
  assign memWdata = r_wdata;
  assign cpuRdata = r_cpuRdata;
  assign dbgRdata = r_dbgRdata;
  assign errOwner = r_errOwner;
  assign cpuStall = cpuReq & ~cpuAck;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single access, fair alternation, timeout,
// ack at the expiry boundary, reset mid-access and back-to-back CPU accesses.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpuReq, cpuWe;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuWdata, cpuRdata;
  logic        cpuAck, cpuStall;
  logic        dbgReq, dbgWe;
  logic [15:0] dbgAddr;
  logic [7:0]  dbgWdata, dbgRdata;
  logic        dbgAck;
  logic        memReq, memWe;
  logic [15:0] memAddr;
  logic [7:0]  memWdata, memRdata;
  logic        memAck;
  logic        errPulse, errOwner;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_cpu_rd;
  logic [7:0] exp_dbg_rd;

  mem_bus_arbiter #(
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpuReq   (cpuReq),
    .cpuWe    (cpuWe),
    .cpuAddr  (cpuAddr),
    .cpuWdata (cpuWdata),
    .cpuRdata (cpuRdata),
    .cpuAck   (cpuAck),
    .cpuStall (cpuStall),
    .dbgReq   (dbgReq),
    .dbgWe    (dbgWe),
    .dbgAddr  (dbgAddr),
    .dbgWdata (dbgWdata),
    .dbgRdata (dbgRdata),
    .dbgAck   (dbgAck),
    .memReq   (memReq),
    .memWe    (memWe),
    .memAddr  (memAddr),
    .memWdata (memWdata),
    .memRdata (memRdata),
    .memAck   (memAck),
    .errPulse (errPulse),
    .errOwner (errOwner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts in IDLE with the owner's request already driven; ends in the IDLE
  // cycle after the ack. dly = WAIT cycles before the one carrying memAck.
  task automatic do_access(input string tag, input bit own, input logic [15:0] addr,
                           input bit we, input logic [7:0] wd, input logic [7:0] rd,
                           input int dly, input bit [1:0] drop);
    tick();
    chk({tag, ".memReq"},  32'(memReq), 32'd1);
    chk({tag, ".memAddr"}, 32'(memAddr), 32'(addr));
    chk({tag, ".memWe"},   32'(memWe), 32'(we));
    if (we) chk({tag, ".memWdata"}, 32'(memWdata), 32'(wd));
    chk({tag, ".stallW"},  32'(cpuStall), 32'(cpuReq));
    for (int i = 0; i < dly; i++) begin
      tick();
      chk({tag, ".memReqHold"}, 32'(memReq), 32'd1);
      chk({tag, ".noAckW"}, 32'(cpuAck | dbgAck), 32'd0);
    end
    memAck   = 1'b1;
    memRdata = rd;
    tick();
    memAck   = 1'b0;
    memRdata = ~rd;
    if (own) exp_dbg_rd = rd;
    else     exp_cpu_rd = rd;
    chk({tag, ".cpuAck"},   32'(cpuAck), 32'(!own));
    chk({tag, ".dbgAck"},   32'(dbgAck), 32'(own));
    chk({tag, ".errPulse"}, 32'(errPulse), 32'd0);
    chk({tag, ".memReqR"},  32'(memReq), 32'd0);
    chk({tag, ".cpuRdata"}, 32'(cpuRdata), 32'(exp_cpu_rd));
    chk({tag, ".dbgRdata"}, 32'(dbgRdata), 32'(exp_dbg_rd));
    chk({tag, ".stallR"},   32'(cpuStall), 32'(cpuReq && own));
    if (drop[0]) cpuReq = 1'b0;
    if (drop[1]) dbgReq = 1'b0;
    tick();
    chk({tag, ".ackIdle"},  32'(cpuAck | dbgAck), 32'd0);
    chk({tag, ".memReqI"},  32'(memReq), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
    dbgReq = 1'b0; dbgWe = 1'b0; dbgAddr = '0; dbgWdata = '0;
    memRdata = '0; memAck = 1'b0;
    exp_cpu_rd = '0; exp_dbg_rd = '0;
    tick();
    tick();
    chk("rst.memReq",   32'(memReq), 32'd0);
    chk("rst.acks",     32'({cpuAck, dbgAck}), 32'd0);
    chk("rst.errPulse", 32'(errPulse), 32'd0);
    chk("rst.errOwner", 32'(errOwner), 32'd0);
    chk("rst.rdata",    32'({cpuRdata, dbgRdata}), 32'd0);
    chk("rst.memAddr",  32'(memAddr), 32'd0);
    chk("rst.memWe",    32'(memWe), 32'd0);

    // Single CPU read, memAck two cycles after memReq rises
    reset = 1'b0;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'h1234; cpuWdata = 8'h00;
    #1;
    chk("t1.stallIdle", 32'(cpuStall), 32'd1);
    do_access("t1", 1'b0, 16'h1234, 1'b0, 8'h00, 8'hA5, 2, 2'b01);
    chk("t1.rdHold", 32'(cpuRdata), 32'hA5);

    // Both requesters held across four accesses after a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cpu_rd = '0; exp_dbg_rd = '0;
    cpuReq = 1'b1; cpuAddr = 16'h1111;
    dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 16'h2222;
    do_access("t2a", 1'b0, 16'h1111, 1'b0, 8'h00, 8'h11, 0, 2'b00);
    do_access("t2b", 1'b1, 16'h2222, 1'b0, 8'h00, 8'h22, 0, 2'b00);
    do_access("t2c", 1'b0, 16'h1111, 1'b0, 8'h00, 8'h33, 1, 2'b00);
    do_access("t2d", 1'b1, 16'h2222, 1'b0, 8'h00, 8'h44, 0, 2'b11);

    // Debug write that memory never acknowledges
    dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 16'h00FF; dbgWdata = 8'h3C;
    tick();
    chk("t3.memReq",   32'(memReq), 32'd1);
    chk("t3.memWe",    32'(memWe), 32'd1);
    chk("t3.memAddr",  32'(memAddr), 32'h00FF);
    chk("t3.memWdata", 32'(memWdata), 32'h3C);
    for (int i = 2; i <= 15; i++) begin
      tick();
      chk("t3.memReqHold", 32'(memReq), 32'd1);
      chk("t3.noErrYet",   32'({errPulse, dbgAck}), 32'd0);
    end
    tick();
    exp_dbg_rd = 8'hFF;
    chk("t3.memReqLow", 32'(memReq), 32'd0);
    chk("t3.dbgAck",    32'(dbgAck), 32'd1);
    chk("t3.errPulse",  32'(errPulse), 32'd1);
    chk("t3.errOwner",  32'(errOwner), 32'd1);
    chk("t3.dbgRdata",  32'(dbgRdata), 32'hFF);
    chk("t3.cpuAck",    32'(cpuAck), 32'd0);
    chk("t3.cpuRdata",  32'(cpuRdata), 32'(exp_cpu_rd));
    dbgReq = 1'b0; dbgWe = 1'b0;
    tick();
    chk("t3.errDone",   32'(errPulse), 32'd0);
    chk("t3.errHeld",   32'(errOwner), 32'd1);

    // memAck lands in the 15th WAIT cycle: still a success
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'h0ABC;
    do_access("t4", 1'b0, 16'h0ABC, 1'b0, 8'h00, 8'h5A, 14, 2'b01);
    chk("t4.errOwnerHeld", 32'(errOwner), 32'd1);

    // Reset in the middle of WAIT, then a stray memAck
    cpuReq = 1'b1; cpuAddr = 16'h0777;
    tick();
    tick();
    chk("t5.memReqW2", 32'(memReq), 32'd1);
    reset = 1'b1;
    cpuReq = 1'b0;
    tick();
    exp_cpu_rd = '0; exp_dbg_rd = '0;
    chk("t5.memReqRst", 32'(memReq), 32'd0);
    memAck = 1'b1; memRdata = 8'hEE;
    tick();
    reset = 1'b0;
    tick();
    memAck = 1'b0;
    chk("t5.noAck",     32'({cpuAck, dbgAck}), 32'd0);
    chk("t5.memReqIdle", 32'(memReq), 32'd0);
    chk("t5.errPulse",  32'(errPulse), 32'd0);
    chk("t5.errOwner",  32'(errOwner), 32'd0);
    chk("t5.cpuRdata",  32'(cpuRdata), 32'h00);
    tick();
    chk("t5.noAckLate", 32'({cpuAck, dbgAck}), 32'd0);
    cpuReq = 1'b1; cpuAddr = 16'h0777;
    do_access("t5", 1'b0, 16'h0777, 1'b0, 8'h00, 8'h77, 0, 2'b01);

    // CPU leaves req high one cycle past ack: a second access follows
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 16'h4321; cpuWdata = 8'h96;
    do_access("t6a", 1'b0, 16'h4321, 1'b1, 8'h96, 8'h01, 0, 2'b00);
    chk("t6.stallIdle", 32'(cpuStall), 32'd1);
    do_access("t6b", 1'b0, 16'h4321, 1'b1, 8'h96, 8'h02, 1, 2'b01);
    cpuWe = 1'b0;
    tick();
    chk("t6.idleAfter", 32'({memReq, cpuStall}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
